// File: rtl/dmem_port_arbiter.sv
// Two-requester burst arbiter for a shared data-memory port: pipeline (A) vs host (B),
// round-robin on contention, bursts capped at MAX_BURST beats, registered beat fields.
module dmem_port_arbiter #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              a_we,
    input  logic              b_we,
    input  logic              a_last,
    input  logic              b_last,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              sel,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic [1:0]        state_q, state_d;
    logic              rr_q, rr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic              owner_req_s;
    logic              owner_last_s;
    logic              beat_s;
    logic              release_s;
    logic              pick_s;
    logic [3:0]        cnt_inc_s;

    // Owner decode, release detection and next-owner selection.
    always_comb begin
        case (state_q)
            OWN_A: begin
                owner_req_s  = a_req;
                owner_last_s = a_last;
            end
            OWN_B: begin
                owner_req_s  = b_req;
                owner_last_s = b_last;
            end
            default: begin
                owner_req_s  = 1'b0;
                owner_last_s = 1'b0;
            end
        endcase

        beat_s    = (state_q != IDLE) && owner_req_s;
        cnt_inc_s = cnt_q + 4'd1;
        // A beat is implied whenever the owner still requests, so last/limit only matter then.
        release_s = (state_q != IDLE) &&
                    (!owner_req_s || owner_last_s || (cnt_inc_s == MAX_B));
        pick_s    = (state_q == IDLE) || release_s;

        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (pick_s) begin
            cnt_d = 4'd0;
            if (a_req && b_req) begin
                state_d = rr_q ? OWN_B : OWN_A;
            end else if (a_req) begin
                state_d = OWN_A;
            end else if (b_req) begin
                state_d = OWN_B;
            end else begin
                state_d = IDLE;
            end
            // Pointer always names the side that did not receive the newest grant.
            if (state_d == OWN_A) begin
                rr_d = 1'b1;
            end else if (state_d == OWN_B) begin
                rr_d = 1'b0;
            end else begin
                rr_d = rr_q;
            end
        end else if (beat_s) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Beat capture: forward the owner's fields one cycle later, hold them otherwise.
    always_comb begin
        mem_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        if (beat_s) begin
            mem_valid_d = 1'b1;
            if (state_q == OWN_B) begin
                mem_addr_d  = b_addr;
                mem_wdata_d = b_wdata;
                mem_we_d    = b_we;
            end else begin
                mem_addr_d  = a_addr;
                mem_wdata_d = a_wdata;
                mem_we_d    = a_we;
            end
        end else begin
            mem_valid_d = 1'b0;
        end
    end

    // State, pointer, counter and beat registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign a_gnt     = (state_q == OWN_A);
    assign b_gnt     = (state_q == OWN_B);
    assign sel       = (state_q == OWN_B);
    assign busy      = (state_q == OWN_A) || (state_q == OWN_B);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule
